coord_mem_arbiter: RTL and testbench
====================================

Name: coord_mem_arbiter

Overview:
- Shares the X/Y coordinate memories between two requesters: requester 0 is the host/loader, requester 1 is the pathfinding engine.
- Drives the mem_id/address/data/wren inputs of the memory interface decoder.
- Routes read data from the selected memory back to the requester that issued the read.
- Single-beat transactions, round-robin arbitration, optional lock for atomic multi-access sequences.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- READ_LATENCY, 2, cycles from address presented on mem_address to valid q_x/q_y (1..4 legal)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 request; held until gnt0
- lock0  in  1  requester 0 wants exclusive ownership after its next grant
- mem_id0  in  3  target memory (000 = XMEM, 001 = YMEM)
- addr0  in  ADDR_W  address
- wdata0  in  DATA_W  write data
- wren0  in  1  1 = write, 0 = read
- gnt0  out  1  one-cycle accept pulse
- rvalid0  out  1  read data valid for requester 0
- req1, lock1, mem_id1, addr1, wdata1, wren1, gnt1, rvalid1: same as the requester 0 set, for requester 1
- rdata  out  DATA_W  read return data; shared, qualified by rvalid0/rvalid1
- mem_id  out  3  to decoder
- mem_address  out  ADDR_W  to decoder
- mem_data  out  DATA_W  to decoder
- mem_wren  out  1  to decoder
- q_x  in  DATA_W  XMEM read data
- q_y  in  DATA_W  YMEM read data

Behaviour:
- Reset state: gnt0 = gnt1 = rvalid0 = rvalid1 = 0; mem_wren = 0; mem_id = mem_address = mem_data = 0; rdata = 0; FSM = IDLE; round-robin pointer = requester 0 preferred; read pipeline cleared.
- FSM states:
  - IDLE: arbitrate both requesters.
  - LOCK0: only req0 may be granted.
  - LOCK1: only req1 may be granted.
- Arbitration in IDLE, per cycle:
  - Only one requesting: grant it.
  - Both requesting: grant the one the pointer prefers.
  - After any grant, the pointer prefers the other requester.
  - At most one gnt per cycle.
  - gnt is combinational from req and state, so a request is accepted in the cycle it is first seen if it wins.
- Lock entry: if lockN = 1 in a cycle where gntN = 1, next state = LOCKN.
- In LOCKN:
  - reqN is granted every cycle it is asserted; the other requester is starved.
  - When lockN = 0 at a clock edge, next state = IDLE; arbitration resumes the following cycle.
  - The pointer is not updated while locked.
- Memory-side outputs are registered. On the cycle after gntN:
  - mem_id = mem_idN, mem_address = addrN, mem_data = wdataN, mem_wren = wrenN.
  - With no grant, mem_wren = 0; address, data and mem_id hold their last values.
- Invalid mem_id (anything other than 000 or 001):
  - Still granted.
  - mem_wren is forced to 0 and mem_id is driven 000.
  - A read returns rdata = 0 with rvalid.
  - The invalid flag travels with the read tag.
- Read return:
  - Every accepted read (wrenN = 0) pushes a tag {valid, requester, mem_id, invalid} into a READ_LATENCY+1 deep shift pipeline.
  - At the pipeline output: rdata = q_x if mem_id = 000, q_y if 001, 0 if invalid.
  - rvalidN pulses 1 cycle, registered.
  - Total latency: gnt cycle T → rvalidN at T + 1 + READ_LATENCY.
- Writes produce no rvalid.
- Back-to-back reads (one per cycle, either requester) return in order, one per cycle, without stalls.
- Simultaneous rvalid0 and rvalid1 is impossible; one accept per cycle guarantees it.
- A read and a write issued in consecutive cycles to the same address: the read sees the memory's own read-during-write behaviour; the arbiter adds no forwarding.
- reset mid-operation: pipeline flushed; in-flight reads never produce rvalid; lock released; mem_wren = 0 on the next cycle.
- req dropped before grant: legal, nothing issued. req changed while waiting: the value sampled in the grant cycle is used.

Decomposition:
- Package coord_mem_pkg:
  - XMEM = 3'b000, YMEM = 3'b001
  - arb_state_t enum {IDLE, LOCK0, LOCK1}
  - rd_tag_t struct {valid, req_id, mem_id[2:0], invalid}
- Sub-module coord_mem_read_pipe: parameterised READ_LATENCY+1 tag shift register plus the q_x/q_y/zero return mux. Outputs rdata, rvalid0, rvalid1.
- The top level holds the FSM, the round-robin pointer and the memory-side output registers.

Test Plan:
- Reset then single read: req0, mem_id0 = 001, addr0 = 0x10, YMEM[0x10] = 0xA5 → gnt0 at T; mem_id = 001, mem_address = 0x10, mem_wren = 0 at T+1; rvalid0 with rdata = 0xA5 at T+3.
- Contention: req0 and req1 held high for 4 cycles, no lock → grants alternate 0,1,0,1; two simultaneous first requests after reset grant requester 0 first.
- Lock: req1 + lock1 granted at T, req0 high throughout, lock1 dropped at T+3 → gnt1 at T..T+3, gnt0 first at T+5.
- Write then read: requester 0 writes 0x3C to XMEM 0x07, then reads it → mem_wren = 1 for exactly one cycle; no rvalid for the write; read returns 0x3C.
- Invalid mem_id = 101 write and read → mem_wren stays 0; read gives rvalid with rdata = 0x00.
- Reset asserted one cycle after a read grant → no rvalid; all outputs back at reset values; FSM in IDLE.

Source files
------------

// File: rtl/coord_mem_pkg.sv
// rtl/coord_mem_pkg.sv - shared types and constants for the coordinate memory arbiter
package coord_mem_pkg;

  localparam logic [2:0] XMEM = 3'b000;
  localparam logic [2:0] YMEM = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       valid;
    logic       req_id;
    logic [2:0] mem_id;
    logic       invalid;
  } rd_tag_t;

  function automatic logic id_invalid(input logic [2:0] id);
    return (id != XMEM) && (id != YMEM);
  endfunction

endpackage

// File: rtl/coord_mem_read_pipe.sv
// rtl/coord_mem_read_pipe.sv - read tag delay line and return data mux
// The output stage lines up with q_x/q_y for the address issued READ_LATENCY cycles earlier.
module coord_mem_read_pipe
  import coord_mem_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  rd_tag_t           push_tag,
  input  logic [DATA_W-1:0] q_x,
  input  logic [DATA_W-1:0] q_y,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid0,
  output logic              rvalid1
);

  rd_tag_t stage [0:READ_LATENCY];
  rd_tag_t out_tag;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= READ_LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_tag = stage[READ_LATENCY];
  assign rvalid0 = out_tag.valid && !out_tag.req_id;
  assign rvalid1 = out_tag.valid && out_tag.req_id;

  // Zero whenever nothing is returning, so rdata is clean out of reset.
  always_comb begin
    rdata = '0;
    if (out_tag.valid && !out_tag.invalid) begin
      rdata = (out_tag.mem_id == YMEM) ? q_y : q_x;
    end
  end

endmodule

// File: rtl/coord_mem_arbiter.sv
// rtl/coord_mem_arbiter.sv - round-robin arbiter with lock between host and pathfinding engine
// Grants are combinational; memory-side outputs and read returns are registered.
module coord_mem_arbiter
  import coord_mem_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              lock0,
  input  logic [2:0]        mem_id0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              wren0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              lock1,
  input  logic [2:0]        mem_id1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              wren1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [2:0]        mem_id,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] q_x,
  input  logic [DATA_W-1:0] q_y
);

  arb_state_t        state;
  logic              pref;
  logic              grant0;
  logic              grant1;
  logic              any_gnt;
  logic [2:0]        sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wren;
  logic              sel_inv;
  rd_tag_t           push_tag;

  // pref = 1 means requester 1 wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || !pref)) grant0 = 1'b1;
        else if (req1)                grant1 = 1'b1;
      end
      LOCK0:   grant0 = req0;
      LOCK1:   grant1 = req1;
      default: ;
    endcase
  end

  assign gnt0    = grant0;
  assign gnt1    = grant1;
  assign any_gnt = grant0 | grant1;

  always_comb begin
    sel_id    = grant1 ? mem_id1 : mem_id0;
    sel_addr  = grant1 ? addr1   : addr0;
    sel_wdata = grant1 ? wdata1  : wdata0;
    sel_wren  = grant1 ? wren1   : wren0;
    sel_inv   = id_invalid(sel_id);
  end

  always_comb begin
    push_tag         = '0;
    push_tag.valid   = any_gnt && !sel_wren;
    push_tag.req_id  = grant1;
    push_tag.mem_id  = sel_id;
    push_tag.invalid = sel_inv;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pref        <= 1'b0;
      mem_id      <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
    end else begin
      if (any_gnt) begin
        mem_id      <= sel_inv ? XMEM : sel_id;
        mem_address <= sel_addr;
        mem_data    <= sel_wdata;
        mem_wren    <= sel_wren && !sel_inv;
      end else begin
        mem_wren    <= 1'b0;
      end

      // The pointer only moves on grants made while arbitrating.
      case (state)
        IDLE: begin
          if (any_gnt) pref <= grant0;
          if (grant0 && lock0)      state <= LOCK0;
          else if (grant1 && lock1) state <= LOCK1;
        end
        LOCK0:   if (!lock0) state <= IDLE;
        LOCK1:   if (!lock1) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  coord_mem_read_pipe #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clock    (clock),
    .reset    (reset),
    .push_tag (push_tag),
    .q_x      (q_x),
    .q_y      (q_y),
    .rdata    (rdata),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1)
  );

endmodule

// File: tb/tb_coord_mem_arbiter.sv
// tb/tb_coord_mem_arbiter.sv - scoreboard bench for coord_mem_arbiter
module tb_coord_mem_arbiter;

  localparam int RL = 2;

  typedef struct {
    logic       req;
    logic       lock;
    logic [2:0] id;
    logic [7:0] addr;
    logic [7:0] data;
    logic       wren;
  } rq_t;

  typedef struct {
    logic       who;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rq_t in0 = '{0, 0, 3'd0, 8'd0, 8'd0, 0};
  rq_t in1 = '{0, 0, 3'd0, 8'd0, 8'd0, 0};
  rq_t idle_rq = '{0, 0, 3'd0, 8'd0, 8'd0, 0};

  logic       gnt0, gnt1, rvalid0, rvalid1, mem_wren;
  logic [7:0] rdata, mem_address, mem_data, q_x, q_y;
  logic [2:0] mem_id;

  coord_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset(reset),
    .req0(in0.req), .lock0(in0.lock), .mem_id0(in0.id), .addr0(in0.addr),
    .wdata0(in0.data), .wren0(in0.wren), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(in1.req), .lock1(in1.lock), .mem_id1(in1.id), .addr1(in1.addr),
    .wdata1(in1.data), .wren1(in1.wren), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_id(mem_id), .mem_address(mem_address),
    .mem_data(mem_data), .mem_wren(mem_wren), .q_x(q_x), .q_y(q_y)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit mon_en  = 0;
  bit started = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_x(input logic [7:0] a);
    return a * 8'd3 + 8'd1;
  endfunction
  function automatic logic [7:0] init_y(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  // Memory model: synchronous read, old data on read-during-write, RL cycles address to q.
  bit [7:0] mem_x [256];
  bit [7:0] mem_y [256];
  bit       wx [256];
  bit       wy [256];
  logic [7:0] dx [RL];
  logic [7:0] dy [RL];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) mon_en <= 1;
    dx[0] <= wx[mem_address] ? mem_x[mem_address] : init_x(mem_address);
    dy[0] <= wy[mem_address] ? mem_y[mem_address] : init_y(mem_address);
    for (int i = 1; i < RL; i++) begin
      dx[i] <= dx[i-1];
      dy[i] <= dy[i-1];
    end
    if (mem_wren && mem_id == 3'b000) begin
      mem_x[mem_address] <= mem_data;
      wx[mem_address]    <= 1;
    end
    if (mem_wren && mem_id == 3'b001) begin
      mem_y[mem_address] <= mem_data;
      wy[mem_address]    <= 1;
    end
  end
  assign q_x = dx[RL-1];
  assign q_y = dy[RL-1];

  // Reference model at transaction level: who owns the bus, who is next, what memory holds.
  bit [7:0] ref_x [256];
  bit [7:0] ref_y [256];
  bit       rwx [256];
  bit       rwy [256];
  int       owner = 0;
  bit       next_pref = 0;
  logic [2:0] e_id;
  logic [7:0] e_addr, e_data;
  logic       e_wren;

  always @(negedge clock) begin
    int   g;
    int   cur;
    rq_t  s;
    bit   inv;
    exp_t e;
    if (reset) begin
      owner = 0; next_pref = 0;
      e_id = 0; e_addr = 0; e_data = 0; e_wren = 0;
      started = 1;
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    end else if (started) begin
      chk("mem_id", {29'd0, mem_id}, {29'd0, e_id});
      chk("mem_address", {24'd0, mem_address}, {24'd0, e_addr});
      chk("mem_data", {24'd0, mem_data}, {24'd0, e_data});
      chk("mem_wren", {31'd0, mem_wren}, {31'd0, e_wren});
      cur = owner;
      g = -1;
      if (cur == 0) begin
        if (in0.req && in1.req) g = next_pref ? 1 : 0;
        else if (in0.req)       g = 0;
        else if (in1.req)       g = 1;
      end else if (cur == 1) begin
        if (in0.req) g = 0;
      end else begin
        if (in1.req) g = 1;
      end
      chk("gnt0", {31'd0, gnt0}, {31'd0, g == 0});
      chk("gnt1", {31'd0, gnt1}, {31'd0, g == 1});
      e_wren = 0;
      if (g >= 0) begin
        s   = (g == 1) ? in1 : in0;
        inv = (s.id != 3'b000) && (s.id != 3'b001);
        e_id = inv ? 3'b000 : s.id;
        e_addr = s.addr;
        e_data = s.data;
        e_wren = s.wren && !inv;
        if (s.wren) begin
          if (!inv && s.id == 3'b000) begin ref_x[s.addr] = s.data; rwx[s.addr] = 1; end
          if (!inv && s.id == 3'b001) begin ref_y[s.addr] = s.data; rwy[s.addr] = 1; end
        end else begin
          e.who = (g == 1);
          if (inv)                e.data = 8'h00;
          else if (s.id == 3'b000) e.data = rwx[s.addr] ? ref_x[s.addr] : init_x(s.addr);
          else                     e.data = rwy[s.addr] ? ref_y[s.addr] : init_y(s.addr);
          e.due = cyc + 1 + RL;
          sb.push_back(e);
        end
        if (cur == 0) begin
          next_pref = (g == 0);
          if (s.lock) owner = g + 1;
        end
      end
      if (cur == 1 && !in0.lock) owner = 0;
      if (cur == 2 && !in1.lock) owner = 0;
    end
  end

  // Read-return monitor.
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (rvalid0 && rvalid1) chk("rvalid_both", 1, 0);
      if (rvalid0 || rvalid1) begin
        if (sb.size() == 0) begin
          chk("spurious_rvalid", {31'd0, rvalid1}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("rv_who", {31'd0, rvalid1}, {31'd0, e.who});
          chk("rdata", {24'd0, rdata}, {24'd0, e.data});
          chk("rv_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rv_missing", 0, 1);
      end
    end
  end

  task automatic step(input rq_t a, input rq_t b);
    in0 = a;
    in1 = b;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    step(idle_rq, idle_rq);
    reset = 0;
  endtask

  function automatic rq_t rnd_rq();
    rq_t r;
    r.req  = $urandom_range(0, 1);
    r.lock = ($urandom_range(0, 6) == 0);
    case ($urandom_range(0, 4))
      0, 1:    r.id = 3'b000;
      2, 3:    r.id = 3'b001;
      default: r.id = 3'($urandom_range(2, 7));
    endcase
    r.addr = 8'($urandom_range(0, 15));
    r.data = 8'($urandom);
    r.wren = $urandom_range(0, 1);
    return r;
  endfunction

  initial begin
    rq_t rd_y10, w_x07, r_x07, w_bad, r_bad, rd1, rd0, lk1, rd0b;
    rd_y10 = '{1, 0, 3'b001, 8'h10, 8'h00, 0};
    w_x07  = '{1, 0, 3'b000, 8'h07, 8'h3C, 1};
    r_x07  = '{1, 0, 3'b000, 8'h07, 8'h00, 0};
    w_bad  = '{1, 0, 3'b101, 8'h05, 8'hFF, 1};
    r_bad  = '{1, 0, 3'b101, 8'h05, 8'h00, 0};
    rd0    = '{1, 0, 3'b000, 8'h02, 8'h00, 0};
    rd1    = '{1, 0, 3'b001, 8'h03, 8'h00, 0};
    lk1    = '{1, 1, 3'b001, 8'h04, 8'h00, 0};
    rd0b   = '{1, 0, 3'b001, 8'h09, 8'h00, 0};

    step(idle_rq, idle_rq);
    do_reset();
    #2;
    chk("rst_gnt0", {31'd0, gnt0}, 0);
    chk("rst_gnt1", {31'd0, gnt1}, 0);
    chk("rst_rvalid0", {31'd0, rvalid0}, 0);
    chk("rst_rvalid1", {31'd0, rvalid1}, 0);
    chk("rst_rdata", {24'd0, rdata}, 0);
    chk("rst_mem_wren", {31'd0, mem_wren}, 0);
    @(posedge clock);
    #1;

    step(rd_y10, idle_rq);
    repeat (RL + 3) step(idle_rq, idle_rq);

    do_reset();
    repeat (4) step(rd0, rd1);
    repeat (RL + 2) step(idle_rq, idle_rq);

    do_reset();
    step(idle_rq, lk1);
    repeat (3) step(rd0b, lk1);
    repeat (3) step(rd0b, idle_rq);
    repeat (RL + 2) step(idle_rq, idle_rq);

    step(w_x07, idle_rq);
    step(r_x07, idle_rq);
    step(w_bad, idle_rq);
    step(r_bad, idle_rq);
    repeat (RL + 3) step(idle_rq, idle_rq);

    repeat (3000) step(rnd_rq(), rnd_rq());
    repeat (RL + 3) step(idle_rq, idle_rq);

    do_reset();
    step(rd0, idle_rq);
    reset = 1;
    step(idle_rq, idle_rq);
    reset = 0;
    repeat (RL + 4) step(idle_rq, idle_rq);
    step(rd0, rd1);
    repeat (RL + 4) step(idle_rq, idle_rq);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
